// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: mode presets, sync polarity codes, counter width helper.
package vga_timing_pkg;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        bit          sync_pol;
    } vga_mode_t;

    // 640x480 @ 60 Hz, 25 MHz pixel clock
    localparam vga_mode_t MODE_640X480_60 = '{640, 16, 96, 48, 480, 10, 2, 33, SYNC_ACTIVE_LOW};
    // 800x600 @ 72 Hz, 50 MHz pixel clock
    localparam vga_mode_t MODE_800X600_72 = '{800, 56, 120, 64, 600, 37, 6, 23, SYNC_ACTIVE_HIGH};

    // Bits needed for a counter running 0..n-1 (at least 1)
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// ce-qualified shift register; resets every stage to BLANK, depth 0 is a plain wire.
module vga_delay_line #(
    parameter int unsigned    W     = 1,
    parameter int unsigned    DEPTH = 0,
    parameter logic [W-1:0]   BLANK = '0
) (
    input  logic         clk_25M,
    input  logic         reset,
    input  logic         ce,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{clk_25M, reset, ce};
            assign dout        = din;
        end else begin : g_pipe
            logic [W-1:0] stage [DEPTH];

            // Shift payload one stage per enabled pixel; blank on reset
            always_ff @(posedge clk_25M or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < int'(DEPTH); i++) stage[i] <= BLANK;
                end else if (ce) begin
                    stage[0] <= din;
                    for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: request-side counters plus a display side lagging by LEAD pixels.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int unsigned LEAD     = 0,
    parameter int unsigned FRAME_W  = 8,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = cnt_w(H_TOTAL),
    localparam int unsigned VW      = cnt_w(V_TOTAL)
) (
    input  logic               clk_25M,
    input  logic               reset,
    input  logic               ce,
    output logic [HW-1:0]      req_x,
    output logic [VW-1:0]      req_y,
    output logic               req_valid,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [HW-1:0]      disp_x,
    output logic [VW-1:0]      disp_y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    // Reject degenerate modes at elaboration
    generate
        if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1
            || LEAD > 7 || FRAME_W < 1) begin : g_bad_params
            $error("vga_timing_gen: porch/sync must be >= 1, LEAD <= 7, FRAME_W >= 1");
        end
    endgenerate

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam int unsigned   HS_START  = H_ACTIVE + H_FP;
    localparam int unsigned   HS_END    = HS_START + H_SYNC;
    localparam int unsigned   VS_START  = V_ACTIVE + V_FP;
    localparam int unsigned   VS_END    = VS_START + V_SYNC;
    localparam logic          SYNC_IDLE = !SYNC_POL;
    localparam int unsigned   PW        = HW + VW + 5;
    localparam logic [PW-1:0] BLANK     = {HW'(0), VW'(0), 1'b0, SYNC_IDLE, SYNC_IDLE, 1'b0, 1'b0};

    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          wrap_h;
    logic          wrap_v;
    logic          hs_lvl;
    logic          vs_lvl;
    logic          ls_r;
    logic          fs_r;
    logic [PW-1:0] req_payload;
    logic [PW-1:0] disp_payload;

    // Next raster position: h wraps at line end and carries into v
    always_comb begin
        wrap_h = (req_x == H_LAST);
        wrap_v = wrap_h && (req_y == V_LAST);
        h_nxt  = wrap_h ? '0 : req_x + HW'(1);
        v_nxt  = req_y;
        if (wrap_h) v_nxt = (req_y == V_LAST) ? '0 : req_y + VW'(1);
    end

    // Request-side position, qualifiers and frame counter, all advanced together
    always_ff @(posedge clk_25M or negedge reset) begin
        if (!reset) begin
            req_x     <= '0;
            req_y     <= '0;
            req_valid <= 1'b1;
            hs_lvl    <= SYNC_IDLE;
            vs_lvl    <= SYNC_IDLE;
            ls_r      <= 1'b1;
            fs_r      <= 1'b1;
            frame_cnt <= '0;
        end else if (ce) begin
            req_x     <= h_nxt;
            req_y     <= v_nxt;
            req_valid <= (32'(h_nxt) < H_ACTIVE) && (32'(v_nxt) < V_ACTIVE);
            hs_lvl    <= ((32'(h_nxt) >= HS_START) && (32'(h_nxt) < HS_END)) ? SYNC_POL : SYNC_IDLE;
            vs_lvl    <= ((32'(v_nxt) >= VS_START) && (32'(v_nxt) < VS_END)) ? SYNC_POL : SYNC_IDLE;
            ls_r      <= (h_nxt == '0);
            fs_r      <= (h_nxt == '0) && (v_nxt == '0);
            if (wrap_v) frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end

    assign req_payload = {req_x, req_y, req_valid, hs_lvl, vs_lvl, ls_r, fs_r};

    vga_delay_line #(
        .W     (PW),
        .DEPTH (LEAD),
        .BLANK (BLANK)
    ) u_delay (
        .clk_25M (clk_25M),
        .reset   (reset),
        .ce      (ce),
        .din     (req_payload),
        .dout    (disp_payload)
    );

    assign {disp_x, disp_y, de, hsync, vsync, line_start, frame_start} = disp_payload;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen across several parameter sets sharing one clock/reset.
module tb_vga_timing_gen;

    logic clk_25M = 1'b0;
    logic reset;
    logic ce_a;
    logic ce_h;
    int   total = 0;
    int   bad   = 0;

    always #20 clk_25M = ~clk_25M;

    // default mode, LEAD=0
    logic [9:0] d_rx, d_ry, d_dx, d_dy;
    logic       d_rv, d_hs, d_vs, d_de, d_ls, d_fs;
    logic [7:0] d_fc;
    // LEAD=3
    logic [9:0] l_rx, l_ry, l_dx, l_dy;
    logic       l_rv, l_hs, l_vs, l_de, l_ls, l_fs;
    logic [7:0] l_fc;
    // ce one clock in two
    logic [9:0] h_rx, h_ry, h_dx, h_dy;
    logic       h_rv, h_hs, h_vs, h_de, h_ls, h_fs;
    logic [7:0] h_fc;
    // SYNC_POL=1
    logic [9:0] p_rx, p_ry, p_dx, p_dy;
    logic       p_rv, p_hs, p_vs, p_de, p_ls, p_fs;
    logic [7:0] p_fc;
    // tiny 7x7 mode, FRAME_W=2
    logic [2:0] s_rx, s_ry, s_dx, s_dy;
    logic       s_rv, s_hs, s_vs, s_de, s_ls, s_fs;
    logic [1:0] s_fc;

    vga_timing_gen u_def (
        .clk_25M(clk_25M), .reset(reset), .ce(ce_a), .req_x(d_rx), .req_y(d_ry), .req_valid(d_rv),
        .hsync(d_hs), .vsync(d_vs), .de(d_de), .disp_x(d_dx), .disp_y(d_dy),
        .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc));

    vga_timing_gen #(.LEAD(3)) u_l3 (
        .clk_25M(clk_25M), .reset(reset), .ce(ce_a), .req_x(l_rx), .req_y(l_ry), .req_valid(l_rv),
        .hsync(l_hs), .vsync(l_vs), .de(l_de), .disp_x(l_dx), .disp_y(l_dy),
        .line_start(l_ls), .frame_start(l_fs), .frame_cnt(l_fc));

    vga_timing_gen u_half (
        .clk_25M(clk_25M), .reset(reset), .ce(ce_h), .req_x(h_rx), .req_y(h_ry), .req_valid(h_rv),
        .hsync(h_hs), .vsync(h_vs), .de(h_de), .disp_x(h_dx), .disp_y(h_dy),
        .line_start(h_ls), .frame_start(h_fs), .frame_cnt(h_fc));

    vga_timing_gen #(.SYNC_POL(1'b1)) u_pol (
        .clk_25M(clk_25M), .reset(reset), .ce(ce_a), .req_x(p_rx), .req_y(p_ry), .req_valid(p_rv),
        .hsync(p_hs), .vsync(p_vs), .de(p_de), .disp_x(p_dx), .disp_y(p_dy),
        .line_start(p_ls), .frame_start(p_fs), .frame_cnt(p_fc));

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1), .FRAME_W(2)
    ) u_sm (
        .clk_25M(clk_25M), .reset(reset), .ce(ce_a), .req_x(s_rx), .req_y(s_ry), .req_valid(s_rv),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .disp_x(s_dx), .disp_y(s_dy),
        .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc));

    // One clock; outputs are sampled 1 ns after the edge, ce_h alternates
    task automatic tick();
        @(posedge clk_25M);
        #1;
        ce_h = ~ce_h;
    endtask

    // Reset pulse; returns just after release with ce_h=1 for the first edge
    task automatic do_reset();
        reset = 1'b0;
        ce_h  = 1'b1;
        repeat (2) @(posedge clk_25M);
        #1;
        reset = 1'b1;
        ce_h  = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ce_a  = 1'b1;
        ce_h  = 1'b1;
        repeat (3) @(posedge clk_25M);
        #1;
        total++; if (d_rx !== 10'd0 || d_ry !== 10'd0) begin bad++; $display("FAIL reset_req_pos got=%0d,%0d exp=0,0", d_rx, d_ry); end
        total++; if (d_rv !== 1'b1) begin bad++; $display("FAIL reset_req_valid got=%b exp=1", d_rv); end
        total++; if (d_hs !== 1'b1 || d_vs !== 1'b1) begin bad++; $display("FAIL reset_syncs got=%b%b exp=11", d_hs, d_vs); end
        total++; if (d_de !== 1'b1 || d_ls !== 1'b1 || d_fs !== 1'b1) begin bad++; $display("FAIL reset_lead0_disp got=%b%b%b exp=111", d_de, d_ls, d_fs); end
        total++; if (d_fc !== 8'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", d_fc); end
        total++; if (l_de !== 1'b0 || l_ls !== 1'b0 || l_fs !== 1'b0 || l_dx !== 10'd0) begin bad++; $display("FAIL reset_lead3_blank got=de%b ls%b fs%b x%0d exp=0", l_de, l_ls, l_fs, l_dx); end
        total++; if (l_hs !== 1'b1 || l_vs !== 1'b1) begin bad++; $display("FAIL reset_lead3_syncs got=%b%b exp=11", l_hs, l_vs); end
        total++; if (p_hs !== 1'b0 || p_vs !== 1'b0) begin bad++; $display("FAIL reset_pol_syncs got=%b%b exp=00", p_hs, p_vs); end
    endtask

    task automatic test_line();
        int x, y;
        do_reset();
        for (int k = 0; k <= 1600; k++) begin
            x = k % 800;
            y = k / 800;
            total++; if (d_rx !== 10'(x) || d_ry !== 10'(y)) begin bad++; $display("FAIL line_req_pos k=%0d got=%0d,%0d exp=%0d,%0d", k, d_rx, d_ry, x, y); end
            total++; if (d_dx !== 10'(x) || d_dy !== 10'(y)) begin bad++; $display("FAIL line_disp_pos k=%0d got=%0d,%0d exp=%0d,%0d", k, d_dx, d_dy, x, y); end
            total++; if (d_hs !== !(x >= 656 && x < 752)) begin bad++; $display("FAIL line_hsync k=%0d got=%b", k, d_hs); end
            total++; if (d_de !== (x < 640) || d_rv !== (x < 640)) begin bad++; $display("FAIL line_de k=%0d got=%b/%b exp=%b", k, d_de, d_rv, x < 640); end
            total++; if (d_ls !== (x == 0) || d_fs !== (x == 0 && y == 0)) begin bad++; $display("FAIL line_markers k=%0d got=%b%b", k, d_ls, d_fs); end
            total++; if (d_vs !== 1'b1) begin bad++; $display("FAIL line_vsync k=%0d got=%b exp=1", k, d_vs); end
            total++; if (p_hs !== (x >= 656 && x < 752) || p_vs !== 1'b0) begin bad++; $display("FAIL pol_syncs k=%0d got=%b%b", k, p_hs, p_vs); end
            tick();
        end
    endtask

    task automatic test_lead3();
        int x, y;
        do_reset();
        for (int k = 0; k <= 805; k++) begin
            x = k % 800;
            y = k / 800;
            total++; if (l_rx !== 10'(x)) begin bad++; $display("FAIL lead3_req_x k=%0d got=%0d exp=%0d", k, l_rx, x); end
            if (k < 3) begin
                total++; if (l_de !== 1'b0 || l_hs !== 1'b1 || l_dx !== 10'd0 || l_ls !== 1'b0) begin bad++; $display("FAIL lead3_blank k=%0d got=de%b hs%b x%0d ls%b", k, l_de, l_hs, l_dx, l_ls); end
            end else begin
                x = (k - 3) % 800;
                y = (k - 3) / 800;
                total++; if (l_dx !== 10'(x) || l_dy !== 10'(y)) begin bad++; $display("FAIL lead3_disp_pos k=%0d got=%0d,%0d exp=%0d,%0d", k, l_dx, l_dy, x, y); end
                total++; if (l_de !== (x < 640)) begin bad++; $display("FAIL lead3_de k=%0d got=%b", k, l_de); end
                total++; if (l_hs !== !(x >= 656 && x < 752)) begin bad++; $display("FAIL lead3_hsync k=%0d got=%b", k, l_hs); end
                total++; if (l_ls !== (x == 0)) begin bad++; $display("FAIL lead3_line_start k=%0d got=%b", k, l_ls); end
            end
            tick();
        end
    endtask

    task automatic test_ce_half();
        int n, x, y;
        do_reset();
        for (int k = 0; k <= 1600; k++) begin
            n = (k + 1) / 2;
            x = n % 800;
            y = n / 800;
            total++; if (h_rx !== 10'(x) || h_ry !== 10'(y)) begin bad++; $display("FAIL half_req_pos k=%0d got=%0d,%0d exp=%0d,%0d", k, h_rx, h_ry, x, y); end
            total++; if (h_dx !== 10'(x) || h_hs !== !(x >= 656 && x < 752) || h_de !== (x < 640)) begin bad++; $display("FAIL half_disp k=%0d got=x%0d hs%b de%b", k, h_dx, h_hs, h_de); end
            total++; if (h_ls !== (x == 0)) begin bad++; $display("FAIL half_line_start k=%0d got=%b", k, h_ls); end
            tick();
        end
    endtask

    task automatic test_frame();
        int x, y, f;
        do_reset();
        for (int k = 0; k <= 200; k++) begin
            x = k % 7;
            y = (k / 7) % 7;
            f = (k / 49) % 4;
            total++; if (s_rx !== 3'(x) || s_ry !== 3'(y)) begin bad++; $display("FAIL frame_pos k=%0d got=%0d,%0d exp=%0d,%0d", k, s_rx, s_ry, x, y); end
            total++; if (s_vs !== !(y >= 4 && y < 6)) begin bad++; $display("FAIL frame_vsync k=%0d got=%b", k, s_vs); end
            total++; if (s_hs !== (x != 5)) begin bad++; $display("FAIL frame_hsync k=%0d got=%b", k, s_hs); end
            total++; if (s_rv !== (x < 4 && y < 3) || s_de !== (x < 4 && y < 3)) begin bad++; $display("FAIL frame_valid k=%0d got=%b%b", k, s_rv, s_de); end
            total++; if (s_fs !== (x == 0 && y == 0)) begin bad++; $display("FAIL frame_start k=%0d got=%b", k, s_fs); end
            total++; if (s_fc !== 2'(f)) begin bad++; $display("FAIL frame_cnt k=%0d got=%0d exp=%0d", k, s_fc, f); end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        repeat (300) tick();
        total++; if (d_rx !== 10'd300 || l_de !== 1'b1) begin bad++; $display("FAIL midrst_pre got=x%0d de%b exp=x300 de1", d_rx, l_de); end
        total++; if (s_fc !== 2'd2) begin bad++; $display("FAIL midrst_pre_fc got=%0d exp=2", s_fc); end
        reset = 1'b0;
        #1;
        total++; if (d_rx !== 10'd0 || d_ry !== 10'd0 || d_hs !== 1'b1 || d_ls !== 1'b1) begin bad++; $display("FAIL midrst_async_def got=x%0d y%0d hs%b ls%b", d_rx, d_ry, d_hs, d_ls); end
        total++; if (l_de !== 1'b0 || l_dx !== 10'd0 || l_ls !== 1'b0) begin bad++; $display("FAIL midrst_async_lead3 got=de%b x%0d ls%b", l_de, l_dx, l_ls); end
        total++; if (s_fc !== 2'd0 || s_rx !== 3'd0) begin bad++; $display("FAIL midrst_async_small got=fc%0d x%0d", s_fc, s_rx); end
        @(posedge clk_25M);
        #1;
        reset = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            total++; if (d_rx !== 10'(k) || d_ry !== 10'd0) begin bad++; $display("FAIL midrst_count k=%0d got=%0d exp=%0d", k, d_rx, k); end
            total++; if (d_fc !== 8'd0 || s_fc !== 2'd0) begin bad++; $display("FAIL midrst_fc k=%0d got=%0d/%0d exp=0", k, d_fc, s_fc); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        ce_a  = 1'b1;
        ce_h  = 1'b1;
        test_reset();
        test_line();
        test_lead3();
        test_ce_half();
        test_frame();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
